// File: rtl/voltmeter_scan_ctl.sv
// voltmeter_scan_ctl: multi-channel ADC scan sequencer with averaging, mV scaling,
// sequential binary-to-BCD conversion and per-channel result storage.
// Ports:
//   clk, rst (async, active-low)     clock and reset
//   scan_en                          run continuous scan
//   cfg_strb, cfg_onehot             channel config pulse / held one-hot select
//   smp_valid, smp_data              ADC sample strobe and data
//   res_valid, res_ch, res_mv        stored-result pulse, channel, binary mV
//   rd_ch, rd_bcd, rd_peak           registered random read of BCD result / peak
//   peak_clr                         clear all peak-hold values
//   busy                             high whenever not IDLE
// Optional: define PEAK_HOLD_EN to add per-channel peak-hold storage.
module voltmeter_scan_ctl #(
  parameter int N_CH     = 4,
  parameter int ADC_W    = 12,
  parameter int VREF_MV  = 3300,
  parameter int AVG_LOG2 = 2,
  parameter int SETTLE   = 2,
  parameter int CH_W     = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_en,
  output logic              cfg_strb,
  output logic [N_CH-1:0]   cfg_onehot,
  input  logic              smp_valid,
  input  logic [ADC_W-1:0]  smp_data,
  output logic              res_valid,
  output logic [CH_W-1:0]   res_ch,
  output logic [13:0]       res_mv,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [15:0]       rd_bcd,
  output logic [15:0]       rd_peak,
  input  logic              peak_clr,
  output logic              busy
);

  localparam int AW = ADC_W + AVG_LOG2;
  localparam int PW = AW + 14;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int NW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [SW-1:0] SET_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [NW-1:0] AVG_LAST = NW'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_SETTLE,
    S_ACC,
    S_SCALE,
    S_BCD,
    S_STORE
  } state_t;

  state_t          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            cfg_strb_q, cfg_strb_d;
  logic [N_CH-1:0] cfg_onehot_q, cfg_onehot_d;
  logic [SW-1:0]   set_cnt_q, set_cnt_d;
  logic [NW-1:0]   avg_cnt_q, avg_cnt_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [13:0]     mv_q, mv_d;
  logic [13:0]     bin_q, bin_d;
  logic [15:0]     bcd_q, bcd_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic            res_valid_q, res_valid_d;
  logic [CH_W-1:0] res_ch_q, res_ch_d;
  logic [13:0]     res_mv_q, res_mv_d;
  logic [15:0]     slot_q [N_CH];
  logic [15:0]     slot_d [N_CH];
  logic [15:0]     rd_bcd_q, rd_bcd_d;
  logic            busy_q, busy_d;

  logic [PW-1:0]   prod;
  logic [15:0]     bcd_adj;

  function automatic logic [15:0] dd_adj(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (r[4*i+:4] >= 4'd5) r[4*i+:4] = r[4*i+:4] + 4'd3;
    end
    return r;
  endfunction

  assign prod    = PW'(acc_q) * PW'(VREF_MV);
  assign bcd_adj = dd_adj(bcd_q);

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    cfg_strb_d   = 1'b0;
    cfg_onehot_d = cfg_onehot_q;
    set_cnt_d    = set_cnt_q;
    avg_cnt_d    = avg_cnt_q;
    acc_d        = acc_q;
    mv_d         = mv_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    bit_cnt_d    = bit_cnt_q;
    res_valid_d  = 1'b0;
    res_ch_d     = res_ch_q;
    res_mv_d     = res_mv_q;
    slot_d       = slot_q;
    unique case (state_q)
      S_IDLE: begin
        if (scan_en) state_d = S_CFG;
      end
      S_CFG: begin
        cfg_onehot_d = N_CH'(1) << ch_q;
        cfg_strb_d   = 1'b1;
        set_cnt_d    = '0;
        avg_cnt_d    = '0;
        acc_d        = '0;
        state_d      = (SETTLE > 0) ? S_SETTLE : S_ACC;
      end
      S_SETTLE: begin
        if (smp_valid) begin
          if (set_cnt_q == SET_LAST) state_d = S_ACC;
          else set_cnt_d = set_cnt_q + SW'(1);
        end
      end
      S_ACC: begin
        if (smp_valid) begin
          acc_d = acc_q + AW'(smp_data);
          if (avg_cnt_q == AVG_LAST) state_d = S_SCALE;
          else avg_cnt_d = avg_cnt_q + NW'(1);
        end
      end
      S_SCALE: begin
        mv_d      = prod[AW+:14];
        bin_d     = prod[AW+:14];
        bcd_d     = '0;
        bit_cnt_d = '0;
        state_d   = S_BCD;
      end
      S_BCD: begin
        // add-3 correction happens before each shift
        bcd_d     = {bcd_adj[14:0], bin_q[13]};
        bin_d     = {bin_q[12:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd13) state_d = S_STORE;
      end
      S_STORE: begin
        for (int i = 0; i < N_CH; i++) begin
          if (ch_q == CH_W'(i)) slot_d[i] = bcd_q;
        end
        res_valid_d = 1'b1;
        res_ch_d    = ch_q;
        res_mv_d    = mv_q;
        ch_d        = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + CH_W'(1);
        state_d     = scan_en ? S_CFG : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    // reading the next-state slots makes a STORE visible one cycle later
    rd_bcd_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_ch == CH_W'(i)) rd_bcd_d = slot_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ch_q         <= '0;
      cfg_strb_q   <= 1'b0;
      cfg_onehot_q <= N_CH'(1);
      set_cnt_q    <= '0;
      avg_cnt_q    <= '0;
      acc_q        <= '0;
      mv_q         <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      bit_cnt_q    <= '0;
      res_valid_q  <= 1'b0;
      res_ch_q     <= '0;
      res_mv_q     <= '0;
      for (int i = 0; i < N_CH; i++) slot_q[i] <= '0;
      rd_bcd_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      cfg_strb_q   <= cfg_strb_d;
      cfg_onehot_q <= cfg_onehot_d;
      set_cnt_q    <= set_cnt_d;
      avg_cnt_q    <= avg_cnt_d;
      acc_q        <= acc_d;
      mv_q         <= mv_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      bit_cnt_q    <= bit_cnt_d;
      res_valid_q  <= res_valid_d;
      res_ch_q     <= res_ch_d;
      res_mv_q     <= res_mv_d;
      slot_q       <= slot_d;
      rd_bcd_q     <= rd_bcd_d;
      busy_q       <= busy_d;
    end
  end

`ifdef PEAK_HOLD_EN
  logic [13:0] pk_mv_q  [N_CH];
  logic [13:0] pk_mv_d  [N_CH];
  logic [15:0] pk_bcd_q [N_CH];
  logic [15:0] pk_bcd_d [N_CH];
  logic [15:0] rd_peak_q, rd_peak_d;

  always_comb begin
    pk_mv_d  = pk_mv_q;
    pk_bcd_d = pk_bcd_q;
    // clear has priority over a same-cycle store
    if (peak_clr) begin
      for (int i = 0; i < N_CH; i++) begin
        pk_mv_d[i]  = '0;
        pk_bcd_d[i] = '0;
      end
    end else if (state_q == S_STORE) begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_q == CH_W'(i) && mv_q > pk_mv_q[i]) begin
          pk_mv_d[i]  = mv_q;
          pk_bcd_d[i] = bcd_q;
        end
      end
    end
    rd_peak_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_ch == CH_W'(i)) rd_peak_d = pk_bcd_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        pk_mv_q[i]  <= '0;
        pk_bcd_q[i] <= '0;
      end
      rd_peak_q <= '0;
    end else begin
      pk_mv_q   <= pk_mv_d;
      pk_bcd_q  <= pk_bcd_d;
      rd_peak_q <= rd_peak_d;
    end
  end

  assign rd_peak = rd_peak_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign rd_peak         = 16'h0000;
`endif

  assign cfg_strb   = cfg_strb_q;
  assign cfg_onehot = cfg_onehot_q;
  assign res_valid  = res_valid_q;
  assign res_ch     = res_ch_q;
  assign res_mv     = res_mv_q;
  assign rd_bcd     = rd_bcd_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_voltmeter_scan_ctl.sv
// tb_voltmeter_scan_ctl: scoreboard bench for voltmeter_scan_ctl (default parameters).
// A feeder queues the expected result per channel; a monitor checks each res_valid.
module tb_voltmeter_scan_ctl;

`ifdef PEAK_HOLD_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_en;
  logic        cfg_strb;
  logic [3:0]  cfg_onehot;
  logic        smp_valid;
  logic [11:0] smp_data;
  logic        res_valid;
  logic [1:0]  res_ch;
  logic [13:0] res_mv;
  logic [1:0]  rd_ch;
  logic [15:0] rd_bcd;
  logic [15:0] rd_peak;
  logic        peak_clr;
  logic        busy;

  always #5 clk = ~clk;

  voltmeter_scan_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .scan_en    (scan_en),
    .cfg_strb   (cfg_strb),
    .cfg_onehot (cfg_onehot),
    .smp_valid  (smp_valid),
    .smp_data   (smp_data),
    .res_valid  (res_valid),
    .res_ch     (res_ch),
    .res_mv     (res_mv),
    .rd_ch      (rd_ch),
    .rd_bcd     (rd_bcd),
    .rd_peak    (rd_peak),
    .peak_clr   (peak_clr),
    .busy       (busy)
  );

  typedef struct {
    int ch;
    int mv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   set_v [4][2];
  int   avg_v [4][4];
  int   exp_mv[4];
  int   exp_ch = 0;
  int   n_res  = 0;
  int   n_cfg  = 0;
  int   smp_k  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic wait_res(input int target, input int budget);
    int n = 0;
    while (n_res < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("result_count", n_res, target);
  endtask

  task automatic wait_k(input int k, input int budget);
    int n = 0;
    while (smp_k != k && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("sample_index", smp_k, k);
  endtask

  task automatic wait_cfg(input int target, input int budget);
    int n = 0;
    while (n_cfg < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("cfg_count", n_cfg, target);
  endtask

  task automatic do_read(input logic [1:0] c, input logic [15:0] bcd,
                         input logic [15:0] pk);
    @(posedge clk);
    #1 rd_ch = c;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("rd_bcd ch%0d", c), rd_bcd, bcd);
    check($sformatf("rd_peak ch%0d", c), rd_peak, PK ? pk : 16'h0);
  endtask

  // feeder: per config strobe, 2 settle + 4 averaged samples, then one stray
  initial begin : feeder
    int c;
    int sv [2];
    int av [4];
    smp_valid = 1'b0;
    smp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst && cfg_strb) begin
        c = exp_ch;
        check("cfg_onehot", cfg_onehot, 32'(1) << c);
        exp_ch = (exp_ch + 1) % 4;
        sv = set_v[c];
        av = avg_v[c];
        sb.push_back('{c, exp_mv[c]});
        smp_k = 0;
        n_cfg++;
        for (int k = 0; k < 6; k++) begin
          repeat (3) @(posedge clk);
          #1 smp_valid = 1'b1;
          if (k < 2) smp_data = 12'(sv[k]);
          else smp_data = 12'(av[k-2]);
          smp_k = k + 1;
          @(posedge clk);
          #1 smp_valid = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 smp_valid = 1'b1;
        smp_data = 12'hFFF;
        @(posedge clk);
        #1 smp_valid = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && res_valid) begin
        n_res++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL res_unexpected: ch %0d mv %0d, required no result",
                   res_ch, res_mv);
        end else begin
          e = sb.pop_front();
          check("res_ch", res_ch, e.ch);
          check("res_mv", res_mv, e.mv);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1);
  end

  initial begin : main
    int base;
    int n;
    rst      = 1'b0;
    scan_en  = 1'b0;
    rd_ch    = '0;
    peak_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_v[i] = '{4095, 4095};
    end
    avg_v[0] = '{4095, 4095, 4095, 4095};
    avg_v[1] = '{2048, 2048, 2048, 2048};
    avg_v[2] = '{0, 0, 0, 0};
    avg_v[3] = '{1000, 1002, 1004, 1006};
    exp_mv   = '{3299, 1650, 0, 808};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst cfg_onehot", cfg_onehot, 4'b0001);
    check("rst cfg_strb", cfg_strb, 1'b0);
    check("rst res_valid", res_valid, 1'b0);
    check("rst res_mv", res_mv, 14'd0);
    check("rst busy", busy, 1'b0);
    check("rst rd_bcd", rd_bcd, 16'h0);
    check("rst rd_peak", rd_peak, 16'h0);

    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 scan_en = 1'b1;
    wait_res(4, 800);
    do_read(2'd0, 16'h3299, 16'h3299);
    do_read(2'd1, 16'h1650, 16'h1650);
    do_read(2'd2, 16'h0000, 16'h0000);
    do_read(2'd3, 16'h0808, 16'h0808);

    // drop scan_en while channel 0 (second pass) is averaging
    wait_k(4, 300);
    @(posedge clk);
    #1 scan_en = 1'b0;
    base = n_res;
    wait_res(base + 1, 300);
    repeat (2) @(negedge clk);
    check("busy after stop", busy, 1'b0);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cfg_strb) n++;
    end
    check("cfg_strb after stop", n, 0);

    // reset in the middle of the BCD conversion of channel 1
    base = n_cfg;
    @(posedge clk);
    #1 scan_en = 1'b1;
    wait_cfg(base + 1, 100);
    wait_k(6, 100);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    scan_en = 1'b0;
    sb.delete();
    exp_ch = 0;
    @(negedge clk);
    check("mid rst cfg_onehot", cfg_onehot, 4'b0001);
    check("mid rst res_valid", res_valid, 1'b0);
    check("mid rst res_mv", res_mv, 14'd0);
    check("mid rst busy", busy, 1'b0);
    check("mid rst rd_bcd", rd_bcd, 16'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (12) @(posedge clk);
    do_read(2'd3, 16'h0000, 16'h0000);
    do_read(2'd0, 16'h0000, 16'h0000);

    // peak-hold: 3000 mV then 1000 mV on channel 0
    avg_v[0]  = '{3723, 3724, 3724, 3724};
    exp_mv[0] = 3000;
    base = n_res;
    @(posedge clk);
    #1 scan_en = 1'b1;
    wait_res(base + 1, 300);
    avg_v[0]  = '{1241, 1241, 1241, 1242};
    exp_mv[0] = 1000;
    wait_res(base + 4, 600);
    @(posedge clk);
    #1 scan_en = 1'b0;
    wait_res(base + 5, 300);
    do_read(2'd1, 16'h1650, 16'h1650);
    do_read(2'd0, 16'h1000, 16'h3000);
    @(posedge clk);
    #1 peak_clr = 1'b1;
    @(posedge clk);
    #1 peak_clr = 1'b0;
    @(negedge clk);
    check("rd_peak after clr", rd_peak, 16'h0);
    check("rd_bcd after clr", rd_bcd, 16'h1000);

    repeat (10) @(negedge clk);
    check("busy at end", busy, 1'b0);
    check("scoreboard empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
